// File: rtl/noniq_duc_pkg.sv
// Shared constants and gain-ramp state encoding for the non-IQ up/down converters.
package noniq_duc_pkg;

    localparam int LO_AMP  = 74840;
    localparam int NUM_DDS = 4;
    localparam int DEN_DDS = 23;

    // Exact width of i*cos - q*sin for 18-bit signed operands
    localparam int MIX_W = 37;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RUN     = 2'd2,
        ST_RAMP_DN = 2'd3
    } gain_state_t;

endpackage

// File: rtl/noniq_duc_gain_ramp.sv
// Drive-gain FSM: ramps g between 0 and 2^GW so the RF output never steps abruptly.
module duc_gain_ramp
    import noniq_duc_pkg::*;
#(
    parameter int GW        = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [GW:0] g,
    output logic        busy,
    output logic        running
);

    localparam logic [GW:0] GMAX   = {1'b1, {GW{1'b0}}};
    localparam int          STEP_C = (RAMP_STEP > (1 << GW)) ? (1 << GW) : RAMP_STEP;
    localparam logic [GW:0] STEP   = STEP_C[GW:0];

    gain_state_t state, state_n;
    logic [GW:0] g_n, g_up, g_dn;

    // Clamped neighbours of g are computed without overflow, so both ramp
    // directions can reverse mid-ramp from whatever g currently holds.
    always_comb begin
        g_up    = (g >= GMAX - STEP) ? GMAX : g + STEP;
        g_dn    = (g <= STEP) ? '0 : g - STEP;
        state_n = state;
        g_n     = g;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    g_n     = STEP;
                    state_n = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP, ST_RAMP_DN: begin
                if (enable) begin
                    g_n     = g_up;
                    state_n = (g_up == GMAX) ? ST_RUN : ST_RAMP_UP;
                end else begin
                    g_n     = g_dn;
                    state_n = (g_dn == '0) ? ST_IDLE : ST_RAMP_DN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    g_n     = g_dn;
                    state_n = (g_dn == '0) ? ST_IDLE : ST_RAMP_DN;
                end
            end
            default: begin
                g_n     = '0;
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            g       <= '0;
            busy    <= 1'b0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            g       <= g_n;
            busy    <= (state_n != ST_IDLE);
            running <= (state_n == ST_RUN);
        end
    end

endmodule

// File: rtl/noniq_duc.sv
// Non-IQ digital upconverter: mixes held I/Q with the LO, rounds, applies the
// ramped drive gain and saturates to a DAC word.
module noniq_duc
    import noniq_duc_pkg::*;
#(
    parameter int DW        = 16,
    parameter int SHIFT     = 17,
    parameter int GW        = 8,
    parameter int RAMP_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic signed [17:0]   cosd,
    input  logic signed [17:0]   sind,
    input  logic signed [17:0]   i_data,
    input  logic signed [17:0]   q_data,
    input  logic                 iq_stb,
    input  logic                 enable,
    output logic signed [DW-1:0] d_out,
    output logic                 clip,
    output logic                 busy,
    output logic                 running
);

    localparam int                      PW  = MIX_W + GW + 2;
    localparam logic signed [MIX_W-1:0] RND = MIX_W'(1) << (SHIFT - 1);

    logic signed [17:0]    i_h, q_h;
    logic signed [35:0]    prod_i, prod_q;
    logic signed [MIX_W-1:0] p, m;
    logic [GW:0]           g;
    logic signed [PW-1:0]  scaled;
    logic signed [DW-1:0]  d_next;
    logic                  clip_next;

    duc_gain_ramp #(
        .GW        (GW),
        .RAMP_STEP (RAMP_STEP)
    ) u_gain (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .g       (g),
        .busy    (busy),
        .running (running)
    );

    // Gain is applied unpipelined so a ramp acts on the very next DAC sample;
    // saturation is detected from the bits above the DAC word's sign bit.
    always_comb begin
        scaled    = (PW'(m) * PW'($signed({1'b0, g}))) >>> GW;
        clip_next = !((&scaled[PW-1:DW-1]) || !(|scaled[PW-1:DW-1]));
        d_next    = scaled[DW-1:0];
        if (clip_next) begin
            d_next = scaled[PW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_h    <= '0;
            q_h    <= '0;
            prod_i <= '0;
            prod_q <= '0;
            p      <= '0;
            m      <= '0;
            d_out  <= '0;
            clip   <= 1'b0;
        end else begin
            if (iq_stb) begin
                i_h <= i_data;
                q_h <= q_data;
            end
            prod_i <= i_h * cosd;
            prod_q <= q_h * sind;
            p      <= MIX_W'(prod_i) - MIX_W'(prod_q);
            m      <= (p + RND) >>> SHIFT;
            d_out  <= d_next;
            clip   <= clip_next;
        end
    end

endmodule
